// File: rtl/da_p2s.sv
// da_p2s: parallel-to-serial frame transmitter (cs_n / sclk / sdata, MSB first).
// A word is accepted on tx_vld & tx_rdy. The block then drives cs_n low,
// holds a setup half-period, clocks out the bits and waits GAP cycles
// before it accepts the next word.
// Build option: define DA_P2S_PARITY_EN to append an odd-parity bit after the LSB.
module da_p2s #(
    parameter int NBITS = 16,
    parameter int DIV   = 4,
    parameter int GAP   = 2
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [NBITS-1:0] tx_data,
    input  logic             tx_vld,
    output logic             tx_rdy,
    output logic             cs_n,
    output logic             sclk,
    output logic             sdata,
    output logic             tx_done
);

`ifdef DA_P2S_PARITY_EN
    localparam int FW = NBITS + 1;   // data bits plus the trailing parity bit
`else
    localparam int FW = NBITS;
`endif
    localparam int HW = $clog2(DIV) + 1;
    // Sized from the frame length so that the parity bit still fits when NBITS=1.
    localparam int BW = $clog2(FW) + 1;
    localparam int GW = $clog2(GAP) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

    state_t          state, state_nx;
    logic [HW-1:0]   hcnt, hcnt_nx;     // clk_sys cycles within the current half-period
    logic [BW-1:0]   bcnt, bcnt_nx;     // sclk rising edges issued in this frame
    logic [GW-1:0]   gcnt, gcnt_nx;     // cycles spent in the inter-frame gap
    logic [FW-1:0]   shreg, shreg_nx;   // outgoing bits; the MSB is the bit on the wire
    logic            cs_n_nx, sclk_nx, sdata_nx, tx_done_nx;

    assign tx_rdy = (state == S_IDLE);

    // State and registered outputs; reset aborts any frame without a tx_done.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            bcnt    <= '0;
            gcnt    <= '0;
            shreg   <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nx;
            hcnt    <= hcnt_nx;
            bcnt    <= bcnt_nx;
            gcnt    <= gcnt_nx;
            shreg   <= shreg_nx;
            cs_n    <= cs_n_nx;
            sclk    <= sclk_nx;
            sdata   <= sdata_nx;
            tx_done <= tx_done_nx;
        end
    end

    // Next-state and next-output decode; the registers hold unless a state changes them.
    always_comb begin
        state_nx   = state;
        hcnt_nx    = hcnt;
        bcnt_nx    = bcnt;
        gcnt_nx    = gcnt;
        shreg_nx   = shreg;
        cs_n_nx    = cs_n;
        sclk_nx    = sclk;
        sdata_nx   = sdata;
        tx_done_nx = 1'b0;
        case (state)
            S_IDLE: begin
                cs_n_nx  = 1'b1;
                sclk_nx  = 1'b0;
                sdata_nx = 1'b0;
                if (tx_vld) begin
`ifdef DA_P2S_PARITY_EN
                    shreg_nx = {tx_data, ~^tx_data};
`else
                    shreg_nx = tx_data;
`endif
                    hcnt_nx  = '0;
                    bcnt_nx  = '0;
                    cs_n_nx  = 1'b0;
                    sdata_nx = tx_data[NBITS-1];
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                hcnt_nx = hcnt + 1'b1;
                // End of the setup half-period: issue the first rising edge.
                if (hcnt == HW'(DIV - 1)) begin
                    hcnt_nx  = '0;
                    sclk_nx  = 1'b1;
                    bcnt_nx  = bcnt + 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                hcnt_nx = hcnt + 1'b1;
                if (hcnt == HW'(DIV - 1)) begin
                    hcnt_nx = '0;
                    if (sclk) begin
                        // Falling edge: move the next bit onto the wire.
                        sclk_nx  = 1'b0;
                        shreg_nx = shreg << 1;
                        sdata_nx = shreg_nx[FW-1];
                    end else if (bcnt == BW'(FW)) begin
                        // Low phase after the last bit is over: close the frame.
                        cs_n_nx    = 1'b1;
                        sdata_nx   = 1'b0;
                        tx_done_nx = 1'b1;
                        gcnt_nx    = '0;
                        state_nx   = S_GAP;
                    end else begin
                        sclk_nx = 1'b1;
                        bcnt_nx = bcnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                gcnt_nx = gcnt + 1'b1;
                if (gcnt == GW'(GAP - 1))
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
